// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared pipeline-control types and defaults
package hazard_stall_controller_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - ID-stage hazard inputs and pipeline-control outputs
interface hazard_stall_if #(
  parameter int REG_W = hazard_stall_controller_pkg::REG_W_DEF,
  parameter int CNT_W = hazard_stall_controller_pkg::CNT_W_DEF
);

  logic             id_valid;
  logic [REG_W-1:0] src_1;
  logic [REG_W-1:0] src_2;
  logic             two_src;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] exe_dest;
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             fwd_en;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;

  logic             freeze;
  logic             stall_id;
  logic             bubble;
  logic             flush;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output id_valid, src_1, src_2, two_src, exe_wb_en, exe_mem_read, exe_dest,
           mem_wb_en, mem_dest, fwd_en, mem_req, mem_ready, branch_taken,
    input  freeze, stall_id, bubble, flush, timeout, stall_cnt, freeze_cnt
  );

  modport slave (
    input  id_valid, src_1, src_2, two_src, exe_wb_en, exe_mem_read, exe_dest,
           mem_wb_en, mem_dest, fwd_en, mem_req, mem_ready, branch_taken,
    output freeze, stall_id, bubble, flush, timeout, stall_cnt, freeze_cnt
  );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// rtl/hazard_stall_controller_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - RAW/load-use stall, branch flush and memory-wait freeze control
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int LOAD_USE_CYC = 1,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  hazard_stall_if.slave bus
);

  localparam int LU_W   = (LOAD_USE_CYC > 1) ? $clog2(LOAD_USE_CYC) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  pipe_state_t      state_q, state_d;
  logic [LU_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic             timeout_q;

  logic m_exe, m_mem, hz;
  logic freeze_c, stall_c, bubble_c, flush_c;

  assign m_exe = bus.id_valid & bus.exe_wb_en &
                 ((bus.src_1 == bus.exe_dest) | (bus.two_src & (bus.src_2 == bus.exe_dest)));
  assign m_mem = bus.id_valid & bus.mem_wb_en &
                 ((bus.src_1 == bus.mem_dest) | (bus.two_src & (bus.src_2 == bus.mem_dest)));
  assign hz    = bus.fwd_en ? (m_exe & bus.exe_mem_read) : (m_exe | m_mem);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Priority: freeze holds everything, then a taken branch, then the hazard FSM.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    freeze_c = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (rst) begin
      freeze_c = bus.mem_req & ~bus.mem_ready;
      if (freeze_c) begin
        state_d = state_q;
      end else if (bus.branch_taken) begin
        flush_c  = 1'b1;
        state_d  = RUN;
        lu_cnt_d = '0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (hz) begin
              stall_c  = 1'b1;
              bubble_c = 1'b1;
              if (bus.fwd_en && (LOAD_USE_CYC > 1)) begin
                state_d  = STALL;
                lu_cnt_d = LU_W'(LOAD_USE_CYC - 1);
              end
            end
          end
          STALL: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            lu_cnt_d = lu_cnt_q - 1'b1;
            if (lu_cnt_q == LU_W'(1)) begin
              state_d = RUN;
            end
          end
          default: begin
            state_d  = RUN;
            lu_cnt_d = '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_c),
    .clear (~freeze_c),
    .count (wait_cnt)
  );

  // Sticky: set on the edge where the wait count reaches MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (freeze_c && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_c),
    .clear (1'b0),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_c),
    .clear (1'b0),
    .count (bus.freeze_cnt)
  );

  assign bus.freeze   = freeze_c;
  assign bus.stall_id = stall_c;
  assign bus.bubble   = bubble_c;
  assign bus.flush    = flush_c;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_stall_if #(.REG_W(4), .CNT_W(16)) bus_a ();
  hazard_stall_if #(.REG_W(4), .CNT_W(2))  bus_b ();

  hazard_stall_controller #(
    .REG_W(4), .LOAD_USE_CYC(3), .MAX_WAIT(4), .CNT_W(16)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  hazard_stall_controller #(
    .REG_W(4), .LOAD_USE_CYC(3), .MAX_WAIT(4), .CNT_W(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Second instance only differs in counter width and sees the same stimulus.
  assign bus_b.id_valid     = bus_a.id_valid;
  assign bus_b.src_1        = bus_a.src_1;
  assign bus_b.src_2        = bus_a.src_2;
  assign bus_b.two_src      = bus_a.two_src;
  assign bus_b.exe_wb_en    = bus_a.exe_wb_en;
  assign bus_b.exe_mem_read = bus_a.exe_mem_read;
  assign bus_b.exe_dest     = bus_a.exe_dest;
  assign bus_b.mem_wb_en    = bus_a.mem_wb_en;
  assign bus_b.mem_dest     = bus_a.mem_dest;
  assign bus_b.fwd_en       = bus_a.fwd_en;
  assign bus_b.mem_req      = bus_a.mem_req;
  assign bus_b.mem_ready    = bus_a.mem_ready;
  assign bus_b.branch_taken = bus_a.branch_taken;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [3:0] dest);
    bus_a.fwd_en       = 1'b1;
    bus_a.id_valid     = 1'b1;
    bus_a.exe_wb_en    = 1'b1;
    bus_a.exe_mem_read = 1'b1;
    bus_a.exe_dest     = dest;
    bus_a.src_1        = 4'd0;
    bus_a.src_2        = dest;
    bus_a.two_src      = 1'b1;
  endtask

  task automatic drop_hazard();
    bus_a.exe_wb_en    = 1'b0;
    bus_a.exe_mem_read = 1'b0;
    bus_a.mem_wb_en    = 1'b0;
    bus_a.two_src      = 1'b0;
  endtask

  initial begin
    rst                = 1'b0;
    bus_a.id_valid     = 1'b0;
    bus_a.src_1        = '0;
    bus_a.src_2        = '0;
    bus_a.two_src      = 1'b0;
    bus_a.exe_wb_en    = 1'b0;
    bus_a.exe_mem_read = 1'b0;
    bus_a.exe_dest     = '0;
    bus_a.mem_wb_en    = 1'b0;
    bus_a.mem_dest     = '0;
    bus_a.fwd_en       = 1'b0;
    bus_a.mem_req      = 1'b0;
    bus_a.mem_ready    = 1'b0;
    bus_a.branch_taken = 1'b0;
    tick();
    tick();

    // Reset state; hazard present but outputs held low by rst=0.
    bus_a.id_valid  = 1'b1;
    bus_a.exe_wb_en = 1'b1;
    bus_a.exe_dest  = 4'd3;
    bus_a.src_1     = 4'd3;
    #1;
    check("rst_stall_id",   bus_a.stall_id,   0);
    check("rst_bubble",     bus_a.bubble,     0);
    check("rst_timeout",    bus_a.timeout,    0);
    check("rst_stall_cnt",  bus_a.stall_cnt,  0);
    check("rst_freeze_cnt", bus_a.freeze_cnt, 0);

    // Plain RAW with exe match, no forwarding.
    rst = 1'b1;
    #1;
    check("raw_exe_stall_id", bus_a.stall_id, 1);
    check("raw_exe_bubble",   bus_a.bubble,   1);
    tick();
    bus_a.exe_wb_en = 1'b0;
    #1;
    check("raw_drop_stall_id", bus_a.stall_id,  0);
    check("raw_drop_bubble",   bus_a.bubble,    0);
    check("raw_stall_cnt",     bus_a.stall_cnt, 1);

    // MEM-stage match and id_valid suppression.
    bus_a.mem_wb_en = 1'b1;
    bus_a.mem_dest  = 4'd7;
    bus_a.src_1     = 4'd7;
    #1;
    check("raw_mem_bubble", bus_a.bubble, 1);
    bus_a.id_valid = 1'b0;
    #1;
    check("id_invalid_bubble", bus_a.bubble, 0);
    bus_a.id_valid = 1'b1;
    drop_hazard();
    #1;

    // Load-use in forwarding mode: src_2 unused gives no stall.
    load_use(4'd5);
    bus_a.two_src = 1'b0;
    #1;
    check("lu_one_src_bubble", bus_a.bubble, 0);
    bus_a.two_src = 1'b1;
    #1;
    check("lu_bubble_0", bus_a.bubble, 1);
    tick();
    drop_hazard();
    #1;
    check("lu_bubble_1", bus_a.bubble, 1);
    tick();
    check("lu_bubble_2", bus_a.bubble, 1);
    tick();
    check("lu_bubble_end", bus_a.bubble, 0);
    check("lu_stall_cnt",  bus_a.stall_cnt, 4);
    check("sat_stall_cnt_b", bus_b.stall_cnt, 3);

    // Freeze during STALL with timeout rising on the 4th wait edge.
    load_use(4'd6);
    #1;
    tick();
    drop_hazard();
    bus_a.mem_req   = 1'b1;
    bus_a.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("frz_freeze_%0d", i),  bus_a.freeze,   1);
      check($sformatf("frz_bubble_%0d", i),  bus_a.bubble,   0);
      check($sformatf("frz_timeout_%0d", i), bus_a.timeout,  0);
      tick();
    end
    check("frz_timeout_set", bus_a.timeout, 1);
    bus_a.mem_ready = 1'b1;
    #1;
    check("frz_release_freeze", bus_a.freeze,     0);
    check("frz_resume_bubble1", bus_a.bubble,     1);
    check("frz_freeze_cnt",     bus_a.freeze_cnt, 4);
    tick();
    bus_a.mem_req = 1'b0;
    #1;
    check("frz_resume_bubble2", bus_a.bubble, 1);
    tick();
    check("frz_resume_end",    bus_a.bubble,    0);
    check("frz_stall_cnt",     bus_a.stall_cnt, 7);
    check("frz_timeout_stays", bus_a.timeout,   1);

    // Taken branch during a load-use stall, then branch under freeze.
    load_use(4'd9);
    #1;
    tick();
    drop_hazard();
    bus_a.branch_taken = 1'b1;
    #1;
    check("br_flush",    bus_a.flush,    1);
    check("br_bubble",   bus_a.bubble,   0);
    check("br_stall_id", bus_a.stall_id, 0);
    tick();
    bus_a.branch_taken = 1'b0;
    #1;
    check("br_run_bubble", bus_a.bubble, 0);
    bus_a.branch_taken = 1'b1;
    bus_a.mem_req      = 1'b1;
    bus_a.mem_ready    = 1'b0;
    #1;
    check("br_frz_flush",  bus_a.flush,  0);
    check("br_frz_freeze", bus_a.freeze, 1);
    bus_a.branch_taken = 1'b0;
    bus_a.mem_req      = 1'b0;
    #1;

    // Reset in the middle of a stall.
    load_use(4'd2);
    #1;
    tick();
    drop_hazard();
    rst = 1'b0;
    #1;
    check("mid_rst_bubble", bus_a.bubble, 0);
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_bubble",     bus_a.bubble,     0);
    check("post_rst_stall_id",   bus_a.stall_id,   0);
    check("post_rst_timeout",    bus_a.timeout,    0);
    check("post_rst_stall_cnt",  bus_a.stall_cnt,  0);
    check("post_rst_freeze_cnt", bus_a.freeze_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
